// File: rtl/ram_cmd_master.sv
// RAM command-interface initiator: turns read/write requests into 2-word din/rx_valid sequences.
// Optional statistics counters are compiled in with `define RAM_MASTER_STATS_EN.
module ram_cmd_master #(
  parameter int          ADDR_SIZE   = 8,
  parameter int          TIMEOUT_CYC = 16,
  parameter logic [7:0]  RD_DUMMY    = 8'h00
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_wr,
  input  logic [ADDR_SIZE-1:0] req_addr,
  input  logic [7:0]           req_wdata,
  output logic                 rsp_valid,
  output logic [7:0]           rsp_rdata,
  output logic                 rsp_err,
  output logic [9:0]           din,
  output logic                 rx_valid,
  input  logic [7:0]           dout,
  input  logic                 tx_valid
`ifdef RAM_MASTER_STATS_EN
  ,
  output logic [15:0]          wr_cnt,
  output logic [15:0]          rd_cnt,
  output logic [15:0]          err_cnt,
  output logic [15:0]          spur_cnt
`endif
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WR_ADDR = 3'd1;
  localparam logic [2:0] ST_WR_DATA = 3'd2;
  localparam logic [2:0] ST_RD_ADDR = 3'd3;
  localparam logic [2:0] ST_RD_DATA = 3'd4;
  localparam logic [2:0] ST_RD_WAIT = 3'd5;
  localparam logic [2:0] ST_RESP    = 3'd6;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

  logic [2:0] state;
  logic [7:0] timer;
  logic [7:0] wdata_q;
  logic [7:0] addr_ext;

  always_comb begin
    addr_ext = '0;
    addr_ext[ADDR_SIZE-1:0] = req_addr;
  end

  // Outputs are loaded on the edge that enters each state, so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      rx_valid  <= 1'b0;
      din       <= 10'h300;
      timer     <= '0;
      wdata_q   <= '0;
    end else begin
      rsp_valid <= 1'b0;
      rx_valid  <= 1'b0;
      req_ready <= 1'b0;
      case (state)
        ST_IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            wdata_q   <= req_wdata;
            rx_valid  <= 1'b1;
            if (req_wr) begin
              state <= ST_WR_ADDR;
              din   <= {2'b00, addr_ext};
            end else begin
              state <= ST_RD_ADDR;
              din   <= {2'b10, addr_ext};
            end
          end
        end
        ST_WR_ADDR: begin
          state    <= ST_WR_DATA;
          din      <= {2'b01, wdata_q};
          rx_valid <= 1'b1;
        end
        ST_WR_DATA: begin
          state     <= ST_RESP;
          rsp_valid <= 1'b1;
          rsp_rdata <= '0;
          rsp_err   <= 1'b0;
        end
        ST_RD_ADDR: begin
          state    <= ST_RD_DATA;
          din      <= {2'b11, RD_DUMMY};
          rx_valid <= 1'b1;
        end
        ST_RD_DATA: begin
          state <= ST_RD_WAIT;
          timer <= '0;
        end
        ST_RD_WAIT: begin
          if (tx_valid) begin
            state     <= ST_RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= dout;
            rsp_err   <= 1'b0;
          end else if (timer == TO_LAST) begin
            state     <= ST_RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
          end else begin
            timer <= timer + 8'd1;
          end
        end
        ST_RESP: begin
          state     <= ST_IDLE;
          req_ready <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef RAM_MASTER_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt   <= '0;
      rd_cnt   <= '0;
      err_cnt  <= '0;
      spur_cnt <= '0;
    end else begin
      if (state == ST_WR_DATA)
        wr_cnt <= sat_inc(wr_cnt);
      if (state == ST_RD_WAIT && tx_valid)
        rd_cnt <= sat_inc(rd_cnt);
      if (state == ST_RD_WAIT && !tx_valid && timer == TO_LAST)
        err_cnt <= sat_inc(err_cnt);
      if (state != ST_RD_WAIT && tx_valid)
        spur_cnt <= sat_inc(spur_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_ram_cmd_master.sv
// Self-checking bench for ram_cmd_master: transaction-level model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_ram_cmd_master;
  localparam int         AS    = 8;
  localparam int         TO    = 16;
  localparam logic [7:0] DUMMY = 8'h00;

  logic        clk = 1'b0;
  logic        rst, req_valid, req_ready, req_wr, rsp_valid, rsp_err, rx_valid, tx_valid;
  logic [7:0]  req_addr, req_wdata, rsp_rdata, dout;
  logic [9:0]  din;
`ifdef RAM_MASTER_STATS_EN
  logic [15:0] wr_cnt, rd_cnt, err_cnt, spur_cnt;
`endif

  ram_cmd_master #(.ADDR_SIZE(AS), .TIMEOUT_CYC(TO), .RD_DUMMY(DUMMY)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .din(din), .rx_valid(rx_valid), .dout(dout), .tx_valid(tx_valid)
`ifdef RAM_MASTER_STATS_EN
    , .wr_cnt(wr_cnt), .rd_cnt(rd_cnt), .err_cnt(err_cnt), .spur_cnt(spur_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] sat16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Transaction model: an accepted request at cycle a puts its command pair on a+1/a+2;
  // writes respond at a+3, reads one cycle after tx_valid in the window a+3..a+2+TO.
  int          cyc = 0;
  bit          armed = 0;
  bit          busy = 0;
  int          acc = 0;
  int          rsp_at = -1;
  bit          t_wr = 0;
  bit          t_err = 0;
  logic [7:0]  t_addr = '0, t_wdata = '0, t_rdata = '0;
  bit          e_ready = 0, e_rx = 0, e_rv = 0, e_err = 0;
  logic [9:0]  e_din = 10'h300;
  logic [7:0]  e_rdata = '0;
  logic [15:0] e_wr = '0, e_rd = '0, e_er = '0, e_sp = '0;

  always @(negedge clk) begin
    bit         n_ready, n_rx, n_rv, in_wait;
    logic [9:0] n_din;
    if (armed) begin
      chk("req_ready", req_ready, e_ready);
      chk("rx_valid", rx_valid, e_rx);
      chk("din", din, e_din);
      chk("rsp_valid", rsp_valid, e_rv);
      chk("rsp_rdata", rsp_rdata, e_rdata);
      chk("rsp_err", rsp_err, e_err);
`ifdef RAM_MASTER_STATS_EN
      chk("wr_cnt", wr_cnt, e_wr);
      chk("rd_cnt", rd_cnt, e_rd);
      chk("err_cnt", err_cnt, e_er);
      chk("spur_cnt", spur_cnt, e_sp);
`endif
    end
    if (rst) begin
      armed = 1; busy = 0; rsp_at = -1;
      e_ready = 0; e_rx = 0; e_rv = 0; e_din = 10'h300; e_rdata = '0; e_err = 0;
      e_wr = '0; e_rd = '0; e_er = '0; e_sp = '0;
    end else if (armed) begin
      n_ready = e_ready; n_rx = 0; n_rv = 0; n_din = e_din;
      in_wait = busy && !t_wr && (cyc >= acc + 3) && (rsp_at < 0);
      if (tx_valid && !in_wait) e_sp = sat16(e_sp);
      if (!busy) begin
        n_ready = 1;
        if (e_ready && req_valid) begin
          busy = 1; acc = cyc; t_wr = req_wr; t_addr = req_addr; t_wdata = req_wdata;
          n_ready = 0; t_rdata = '0; t_err = 0;
          rsp_at = req_wr ? cyc + 3 : -1;
        end
      end
      if (busy) begin
        if (cyc == acc) begin
          n_rx = 1; n_din = {(t_wr ? 2'b00 : 2'b10), t_addr};
        end else if (cyc == acc + 1) begin
          n_rx = 1; n_din = t_wr ? {2'b01, t_wdata} : {2'b11, DUMMY};
        end
        if (in_wait) begin
          if (tx_valid) begin
            rsp_at = cyc + 1; t_rdata = dout; t_err = 0;
          end else if (cyc == acc + 2 + TO) begin
            rsp_at = cyc + 1; t_rdata = '0; t_err = 1;
          end
        end
        if (cyc + 1 == rsp_at) begin
          n_rv = 1; e_rdata = t_rdata; e_err = t_err;
          if (t_wr) e_wr = sat16(e_wr);
          else if (t_err) e_er = sat16(e_er);
          else e_rd = sat16(e_rd);
        end else if (cyc == rsp_at) begin
          busy = 0; n_ready = 1;
        end
      end
      e_ready = n_ready; e_rx = n_rx; e_rv = n_rv; e_din = n_din;
    end
    cyc++;
  end

  task automatic nxt;
    @(posedge clk);
    #2;
  endtask

  task automatic smp;
    @(negedge clk);
  endtask

  // Present a request and hold it until accepted; returns at the drive point of accept+1.
  task automatic issue(input bit wr, input logic [7:0] a, input logic [7:0] d);
    bit ok = 0;
    req_valid = 1; req_wr = wr; req_addr = a; req_wdata = d;
    for (int k = 0; k < 40; k++) begin
      smp;
      if (req_ready) begin ok = 1; break; end
      nxt;
    end
    if (!ok) begin errors++; $display("FAIL accept_wait: got no req_ready expected 1"); end
    nxt;
    req_valid = 0; req_wr = 1'($urandom); req_addr = 8'($urandom); req_wdata = 8'($urandom);
  endtask

  // Full transaction; tx_delay = RD_WAIT cycle index for tx_valid, -1 for never.
  task automatic run_txn(input bit wr, input logic [7:0] a, input logic [7:0] d,
                         input int tx_delay, input logic [7:0] dv);
    bit seen = 0;
    issue(wr, a, d);
    for (int k = 1; k < TO + 8; k++) begin
      if (!wr && tx_delay >= 0 && k == 3 + tx_delay) begin tx_valid = 1; dout = dv; end
      else tx_valid = 0;
      smp;
      seen = rsp_valid;
      nxt;
      if (seen) break;
    end
    tx_valid = 0;
    if (!seen) begin errors++; $display("FAIL rsp_wait: got no rsp_valid expected 1"); end
  endtask

  int n_acc, pulses, early;
  int txp;

  initial begin
    rst = 1; req_valid = 0; req_wr = 0; req_addr = '0; req_wdata = '0; dout = '0; tx_valid = 0;
    repeat (3) @(posedge clk);
    #2 rst = 0;
    smp;
    chk("reset_ready", req_ready, 0);
    chk("reset_din", din, 10'h300);
    chk("reset_rx", rx_valid, 0);
    chk("reset_rsp", rsp_valid, 0);
    nxt;

    // write 3A/C5
    issue(1, 8'h3A, 8'hC5);
    smp; chk("t1_din0", din, 10'h03A); chk("t1_rx0", rx_valid, 1); nxt;
    smp; chk("t1_din1", din, 10'h1C5); chk("t1_rx1", rx_valid, 1); nxt;
    smp; chk("t1_rsp", rsp_valid, 1); chk("t1_err", rsp_err, 0); nxt;

    // read 3A, tx_valid in first RD_WAIT cycle
    issue(0, 8'h3A, 8'h00);
    smp; chk("t2_din0", din, 10'h23A); nxt;
    smp; chk("t2_din1", din, 10'h300); chk("t2_rx1", rx_valid, 1); nxt;
    tx_valid = 1; dout = 8'hC5;
    smp; chk("t2_norsp", rsp_valid, 0); nxt;
    tx_valid = 0; dout = 8'h5A;
    smp; chk("t2_rsp", rsp_valid, 1); chk("t2_rdata", rsp_rdata, 8'hC5); chk("t2_err", rsp_err, 0);
    nxt;

    // read timeout, then a write
    issue(0, 8'h55, 8'h00);
    early = 0;
    for (int k = 1; k <= 3 + TO; k++) begin
      smp;
      if (k == 3 + TO) begin
        chk("t3_rsp", rsp_valid, 1); chk("t3_err", rsp_err, 1); chk("t3_rdata", rsp_rdata, 0);
      end else if (rsp_valid) early++;
      nxt;
    end
    chk("t3_early_rsp", early, 0);
    issue(1, 8'h12, 8'h34);
    smp; nxt; smp; nxt;
    smp; chk("t3_wr_rsp", rsp_valid, 1); chk("t3_wr_err", rsp_err, 0); chk("t3_wr_rdata", rsp_rdata, 0);
    nxt;

    // three back-to-back writes with req_valid held
    req_valid = 1; req_wr = 1; req_addr = 8'hA0; req_wdata = 8'h0F;
    n_acc = 0; pulses = 0;
    for (int k = 0; k < 40 && n_acc < 3; k++) begin
      smp;
      if (req_ready) n_acc++;
      if (rsp_valid) pulses++;
      nxt;
    end
    req_valid = 0;
    repeat (6) begin smp; if (rsp_valid) pulses++; nxt; end
    chk("t4_accepts", n_acc, 3);
    chk("t4_pulses", pulses, 3);

    // reset during RD_DATA
    issue(0, 8'h77, 8'h00);
    smp; nxt;
    rst = 1;
    smp; nxt;
    rst = 0; tx_valid = 1; dout = 8'hAA;
    smp; chk("t5_rx", rx_valid, 0); chk("t5_din", din, 10'h300); chk("t5_rsp", rsp_valid, 0); nxt;
    smp; chk("t5_rsp2", rsp_valid, 0); nxt;
    tx_valid = 0;
    repeat (4) begin smp; nxt; end

`ifdef RAM_MASTER_STATS_EN
    rst = 1; nxt; rst = 0; nxt;
    run_txn(1, 8'h01, 8'h11, -1, 8'h00);
    run_txn(1, 8'h02, 8'h22, -1, 8'h00);
    run_txn(0, 8'h01, 8'h00, 0, 8'h99);
    run_txn(0, 8'h02, 8'h00, -1, 8'h00);
    tx_valid = 1; nxt; nxt; tx_valid = 0; nxt;
    smp;
    chk("t6_wr_cnt", wr_cnt, 2);
    chk("t6_rd_cnt", rd_cnt, 1);
    chk("t6_err_cnt", err_cnt, 1);
    chk("t6_spur_cnt", spur_cnt, 2);
    nxt;
`endif

    // a few mid-window reads through the helper
    run_txn(0, 8'hF0, 8'h00, 5, 8'h3C);
    run_txn(0, 8'h0F, 8'h00, TO - 1, 8'hE1);

    // randomized traffic, model-checked every cycle
    txp = 10;
    for (int k = 0; k < 4000; k++) begin
      if (k % 250 == 0) txp = (($urandom % 3) == 0) ? 1 : ((($urandom % 2) == 0) ? 8 : 40);
      rst       = ($urandom_range(0, 599) == 0);
      req_valid = ($urandom_range(0, 2) == 0);
      req_wr    = 1'($urandom);
      req_addr  = 8'($urandom);
      req_wdata = 8'($urandom);
      tx_valid  = ($urandom_range(0, 99) < txp);
      dout      = 8'($urandom);
      nxt;
    end
    rst = 0; req_valid = 0; tx_valid = 0;
    repeat (TO + 8) nxt;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
